// File: rtl/overlay_pkg.sv
// Shared definitions for the overlay RAM arbiter: controller states and
// the default fill pattern written by the clear sweep.
package overlay_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } state_e;

  localparam logic [7:0] FILL_DEFAULT = 8'h20;

endpackage

// File: rtl/overlay_ram_arbiter.sv
// Two-requester round-robin arbiter in front of one synchronous RAM port,
// with a background sweep that fills the whole RAM with a constant.
module overlay_ram_arbiter
  import overlay_pkg::*;
#(
  parameter int unsigned       AW   = 10,
  parameter int unsigned       DW   = 8,
  parameter logic [DW-1:0]     FILL = DW'(FILL_DEFAULT)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  input  logic          clear_start,
  output logic          clear_busy,
  output logic          clear_done,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_q
);

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;
  logic          rvalid0_q, rvalid0_d;
  logic          rvalid1_q, rvalid1_d;
  logic          done_q, done_d;
  logic          win0, win1;

  // Round-robin: under contention the requester that did not win last goes.
  assign win0 = (state_q == ST_IDLE) && !reset && req0 && (!req1 ||  last_q);
  assign win1 = (state_q == ST_IDLE) && !reset && req1 && (!req0 || !last_q);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; reset is synchronous and wins over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      last_q    <= 1'b1;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      done_q    <= done_d;
    end
  end

  // NOTE: every signal gets a default at the top of the block so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    done_d    = 1'b0;
    rvalid0_d = win0 && !we0;
    rvalid1_d = win1 && !we1;
    if (win0 || win1) last_d = win1;
    unique case (state_q)
      ST_IDLE: begin
        if (clear_start) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (&cnt_q) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    gnt0       = win0;
    gnt1       = win1;
    rvalid0    = rvalid0_q;
    rvalid1    = rvalid1_q;
    rdata      = ram_q;
    clear_busy = (state_q == ST_CLEAR);
    clear_done = done_q;
    ram_we     = 1'b0;
    ram_addr   = '0;
    ram_wdata  = '0;
    if (state_q == ST_CLEAR) begin
      ram_we    = !reset;
      ram_addr  = cnt_q;
      ram_wdata = FILL;
    end else if (win0) begin
      ram_we    = we0;
      ram_addr  = addr0;
      ram_wdata = wdata0;
    end else if (win1) begin
      ram_we    = we1;
      ram_addr  = addr1;
      ram_wdata = wdata1;
    end
  end

endmodule

// File: tb/tb_overlay_ram_arbiter.sv
// Directed bench for overlay_ram_arbiter: vector table for arbitration and
// read latency, hand-written sequences for the clear sweep and reset abort.
module tb_overlay_ram_arbiter;

  localparam int AW = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata;
  logic          clear_start, clear_busy, clear_done;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_q;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  overlay_ram_arbiter #(.AW(AW), .DW(DW), .FILL(8'h20)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .clear_start(clear_start), .clear_busy(clear_busy),
    .clear_done(clear_done), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_q(ram_q)
  );

  // Synchronous RAM, one-cycle read latency, read-before-write.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_q <= mem[ram_addr];
  end

  typedef struct {
    logic          r0, r1, w0, w1;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1;
    logic [3:0]    exp_flags;  // {gnt0, gnt1, rvalid0, rvalid1}
    logic [DW-1:0] exp_rdata;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    clear_start = 0;
  endtask

  // Single req0 read, data checked in the following cycle.
  task automatic read0(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string name);
    tick();
    req0 = 1; we0 = 0; addr0 = a;
    #4 check({name, "_gnt"}, gnt0, 1'b1);
    tick();
    req0 = 0;
    #4 check({name, "_data"}, {rvalid0, rdata}, {1'b1, exp});
  endtask

  task automatic write0(input logic [AW-1:0] a, input logic [DW-1:0] d);
    tick();
    req0 = 1; we0 = 1; addr0 = a; wdata0 = d;
    #4 check("write0_gnt", gnt0, 1'b1);
    tick();
    req0 = 0; we0 = 0;
  endtask

  initial begin
    vecs[0] = '{1,0,1,0, 4'd5,4'd0, 8'hA7,8'h00, 4'b1000, 8'h00};
    vecs[1] = '{1,0,0,0, 4'd5,4'd0, 8'h00,8'h00, 4'b1000, 8'h00};
    vecs[2] = '{0,0,0,0, 4'd0,4'd0, 8'h00,8'h00, 4'b0010, 8'hA7};
    vecs[3] = '{0,1,0,1, 4'd0,4'd3, 8'h00,8'h3C, 4'b0100, 8'h00};
    vecs[4] = '{1,1,0,1, 4'd3,4'd9, 8'h00,8'h55, 4'b1000, 8'h00};
    vecs[5] = '{1,1,0,1, 4'd3,4'd9, 8'h00,8'h55, 4'b0110, 8'h3C};
    vecs[6] = '{1,1,0,1, 4'd3,4'd9, 8'h00,8'h55, 4'b1000, 8'h00};
    vecs[7] = '{1,1,0,1, 4'd3,4'd9, 8'h00,8'h55, 4'b0110, 8'h3C};
    vecs[8] = '{0,1,0,0, 4'd0,4'd9, 8'h00,8'h00, 4'b0100, 8'h00};
    vecs[9] = '{0,0,0,0, 4'd0,4'd0, 8'h00,8'h00, 4'b0001, 8'h55};

    idle_inputs();
    reset = 1;
    repeat (2) tick();
    req0 = 1; we0 = 1;
    #4 check("reset_blocks_req", {gnt0, gnt1, ram_we}, 3'b000);
    idle_inputs();
    tick();
    reset = 0;
    #4 check("reset_state", {gnt0, gnt1, rvalid0, rvalid1, clear_busy, clear_done}, 6'b0);

    // Arbitration / read latency table; contention starts with requester 0.
    for (int i = 0; i < 10; i++) begin
      tick();
      req0 = vecs[i].r0; req1 = vecs[i].r1; we0 = vecs[i].w0; we1 = vecs[i].w1;
      addr0 = vecs[i].a0; addr1 = vecs[i].a1; wdata0 = vecs[i].d0; wdata1 = vecs[i].d1;
      #4;
      check($sformatf("vec%0d_flags", i), {gnt0, gnt1, rvalid0, rvalid1}, vecs[i].exp_flags);
      if (vecs[i].exp_flags[1] || vecs[i].exp_flags[0])
        check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
    end
    idle_inputs();

    // Clear sweep with a read granted in the start cycle.
    tick();
    clear_start = 1; req0 = 1; we0 = 0; addr0 = 4'd5;
    #4 check("clr_start_gnt", {gnt0, clear_busy}, 2'b10);
    for (int i = 0; i < 16; i++) begin
      tick();
      clear_start = (i == 2);
      req0 = 0;
      if (i == 2) begin
        req1 = 1; we1 = 1; addr1 = 4'd4; wdata1 = 8'h99;
      end
      #4;
      if (i == 0) check("clr_rvalid_carry", {rvalid0, rdata}, {1'b1, 8'hA7});
      check($sformatf("clr%0d_bus", i), {clear_busy, ram_we, ram_addr, ram_wdata, gnt0, gnt1},
            {1'b1, 1'b1, 4'(i), 8'h20, 2'b00});
    end
    tick();
    clear_start = 0;
    #4 check("clr_exit", {clear_busy, clear_done, gnt1, ram_we, ram_addr}, {4'b0111, 4'd4});
    tick();
    idle_inputs();
    #4 check("clr_done_pulse", {clear_done, clear_busy}, 2'b00);
    for (int a = 0; a < 16; a++)
      read0(4'(a), (a == 4) ? 8'h99 : 8'h20, $sformatf("fill%0d", a));

    // Reset in the cycle that would write address 7 aborts the sweep.
    write0(4'd7, 8'h11);
    write0(4'd10, 8'h12);
    tick();
    clear_start = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      clear_start = 0;
      if (i == 7) reset = 1;
    end
    #4 check("abort_addr", ram_addr, 4'd7);
    tick();
    reset = 0;
    #4 check("abort_state", {clear_busy, clear_done}, 2'b00);
    tick();
    #4 check("abort_no_done", {clear_busy, clear_done}, 2'b00);
    read0(4'd7, 8'h11, "abort_a7");
    read0(4'd10, 8'h12, "abort_a10");
    read0(4'd6, 8'h20, "abort_a6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/overlay_ram_arbiter.md
OVERLAY_RAM_ARBITER -- requirements
Module: overlay_ram_arbiter

Interface
REQ-001 SHALL have parameters: AW, 10, RAM address width; DW, 8, RAM data width; FILL, 8'h20, value written by the clear sweep.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have ports req0/req1, input, 1 each, access request from requester 0 (host loader) and requester 1 (overlay writer).
REQ-005 SHALL have ports we0/we1, input, 1 each, 1 = write, 0 = read.
REQ-006 SHALL have ports addr0/addr1, input, AW each, access address.
REQ-007 SHALL have ports wdata0/wdata1, input, DW each, write data.
REQ-008 SHALL have ports gnt0/gnt1, output, 1 each, one-cycle pulse: access issued this cycle.
REQ-009 SHALL have ports rvalid0/rvalid1, output, 1 each, read data valid on rdata.
REQ-010 SHALL have port rdata, output, DW, read data, a direct pass-through of ram_q.
REQ-011 SHALL have ports clear_start (input, 1, start fill sweep), clear_busy (output, 1) and clear_done (output, 1, one-cycle pulse).
REQ-012 SHALL have ports ram_we (output, 1), ram_addr (output, AW), ram_wdata (output, DW) and ram_q (input, DW), driving one port of a synchronous RAM with 1-cycle read latency.

Function
REQ-013 SHALL drive ram_we/ram_addr/ram_wdata combinationally from the winner of the current cycle, with ram_we = 0 when no access is issued.
REQ-014 SHALL keep the states IDLE and CLEAR; requester arbitration occurs only in IDLE.
REQ-015 SHALL, in IDLE with exactly one reqN high, issue that access and assert gntN in the same cycle.
REQ-016 SHALL, in IDLE with both requests high, grant the requester other than last_grant (round-robin), then update last_grant to the winner.
REQ-017 SHALL leave last_grant unchanged in cycles without a grant.
REQ-018 SHALL assert rvalidN exactly one cycle after a gntN whose weN = 0, and never after a write.
REQ-019 SHALL issue at most one access per cycle, allowing back-to-back grants with no dead cycle.
REQ-020 SHALL require requesters to hold req/we/addr/wdata stable until gnt; a req dropped before gnt is simply not serviced.
REQ-021 SHALL, on clear_start in IDLE, enter CLEAR on the next edge with sweep counter = 0 and clear_busy = 1; a request present in that same cycle is still granted normally.
REQ-022 SHALL, in CLEAR, write FILL to address counter each cycle, increment counter, and assert no gnt.
REQ-023 SHALL, after the write to address 2^AW-1, return to IDLE, deassert clear_busy, and pulse clear_done for one cycle with that IDLE cycle.
REQ-024 SHALL ignore clear_start while in CLEAR.
REQ-025 SHALL let pending requests wait during CLEAR and arbitrate them on the first IDLE cycle using the retained last_grant.
REQ-026 SHALL allow an rvalid from a read granted in the cycle before entering CLEAR to appear during the first CLEAR cycle.

Reset
REQ-027 SHALL, on reset, set the state to IDLE, counter to 0, last_grant to 1 (requester 0 wins first contention), and gnt0/gnt1/rvalid0/rvalid1/clear_busy/clear_done to 0.
REQ-028 SHALL, on reset mid-clear, abort the sweep with no clear_done and leave RAM contents partially filled.
REQ-029 SHALL give reset priority over clear_start and all requests in the same cycle.

Structure
REQ-030 SHALL place the state enum and the FILL default in a shared package overlay_pkg.
REQ-031 SHALL be a single module with no sub-modules, instantiated beside dpram2 port A.

Verification
REQ-032 Scenario: req0 read addr 5 with RAM[5] = 8'hA7 -> gnt0 in cycle N, rvalid0 = 1 and rdata = 8'hA7 in N+1.
REQ-033 Scenario: req0 and req1 held continuously after reset -> grant sequence 0,1,0,1 on consecutive cycles.
REQ-034 Scenario: clear_start with AW = 4 -> clear_busy for 16 cycles, writes to addresses 0..15 with data 8'h20, clear_done pulses once, then all reads return 8'h20.
REQ-035 Scenario: req1 write raised in the 3rd CLEAR cycle -> no gnt1 until the first IDLE cycle, then gnt1, and that address holds the req1 data.
REQ-036 Scenario: reset asserted at counter 7 -> next cycle IDLE, clear_busy = 0, no clear_done, addresses at and above 7 unchanged.
